// File: rtl/mmm_inv_pkg.sv
// mmm_inv_pkg: shared types and helpers for the modular-inverse engine.
//   status_e : result status codes reported on the status port
//   state_e  : control states of the engine
//   max_iter_default : default RUN step budget for a given operand width
package mmm_inv_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_NOT_INV = 2'd1,
    ST_BAD_MOD = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CHK  = 3'd1,
    RUN  = 3'd2,
    FIN  = 3'd3,
    HOLD = 3'd4
  } state_e;

  // Binary extended Euclid needs at most about 2*WIDTH+2 steps; 4*WIDTH leaves margin.
  function automatic int max_iter_default(input int width);
    return 4 * width;
  endfunction

endpackage

// File: rtl/mmm_mod_half.sv
// mmm_mod_half: modular halving, y = x/2 mod n for odd n.
//   x : value in [0,n)
//   n : odd modulus
//   y : (x + x[0]*n) >> 1, always in [0,n)
module mmm_mod_half #(
  parameter int WIDTH = 260
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] sum_s;
  logic           lsb_unused_s;

  // Odd x gets n added so the sum is even and the shift is exact; the carry bit is kept.
  always_comb begin
    if (x[0]) begin
      sum_s = {1'b0, x} + {1'b0, n};
    end else begin
      sum_s = {1'b0, x};
    end
    y = sum_s[WIDTH:1];
  end

  // The dropped bit is zero by construction.
  assign lsb_unused_s = sum_s[0];

endmodule

// File: rtl/mmm_mod_inv_hs.sv
// mmm_mod_inv_hs: handshaked modular inverse A^-1 mod N (odd N) by binary
// extended Euclid, one reduction step per clock.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake; a, n, neg captured on accept
//   out_valid / out_ready: result handshake; outputs held until accepted
//   result               : inverse (or N - inverse when neg), 0 on error
//   status               : OK / NOT_INVERTIBLE / BAD_MODULUS / TIMEOUT
//   cycles               : RUN steps used for this result
module mmm_mod_inv_hs
  import mmm_inv_pkg::*;
#(
  parameter int WIDTH    = 260,
  parameter int MAX_ITER = max_iter_default(WIDTH),
  parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] n,
  input  logic             neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] THREE_W = {{(WIDTH-2){1'b0}}, 2'b11};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ITER);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, nm_q, nm_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  status_e          code_q, code_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  status_e          status_q, status_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic             accept_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [WIDTH:0]   u_sub_s, x1_sub_s, x2_sub_s;
  logic [WIDTH-1:0] v_sub_s, x1_diff_s, x2_diff_s, x1_half_s, x2_half_s;
  logic [WIDTH-1:0] inv_s, neg_inv_s;

  mmm_mod_half #(.WIDTH(WIDTH)) u_half_x1 (.x(x1_q), .n(nm_q), .y(x1_half_s));
  mmm_mod_half #(.WIDTH(WIDTH)) u_half_x2 (.x(x2_q), .n(nm_q), .y(x2_half_s));

  assign accept_s  = in_valid && in_ready_q;
  assign cnt_inc_s = cnt_q + CNT_ONE;

  // The borrow bit of u-v doubles as the u>=v comparison.
  assign u_sub_s  = {1'b0, u_q} - {1'b0, v_q};
  assign v_sub_s  = v_q - u_q;
  // Coefficients stay in [0,N): a borrow means the difference wrapped, so add N back.
  assign x1_sub_s  = {1'b0, x1_q} - {1'b0, x2_q};
  assign x2_sub_s  = {1'b0, x2_q} - {1'b0, x1_q};
  assign x1_diff_s = x1_sub_s[WIDTH] ? (x1_sub_s[WIDTH-1:0] + nm_q) : x1_sub_s[WIDTH-1:0];
  assign x2_diff_s = x2_sub_s[WIDTH] ? (x2_sub_s[WIDTH-1:0] + nm_q) : x2_sub_s[WIDTH-1:0];

  // x1 tracks u and x2 tracks v; whichever operand reached 1 carries the inverse.
  assign inv_s     = (u_q == ONE_W) ? x1_q : x2_q;
  assign neg_inv_s = (inv_s == ZERO_W) ? ZERO_W : (nm_q - inv_s);

  // Next-state, datapath step and output computation.
  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    v_d      = v_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    nm_d     = nm_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    result_d = result_q;
    status_d = status_q;
    cycles_d = cycles_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          u_d     = a;
          v_d     = n;
          x1_d    = ONE_W;
          x2_d    = ZERO_W;
          nm_d    = n;
          neg_d   = neg;
          cnt_d   = {CNT_W{1'b0}};
          code_d  = ST_OK;
          state_d = CHK;
        end else begin
          state_d = IDLE;
        end
      end
      CHK: begin
        if (!nm_q[0] || (nm_q < THREE_W)) begin
          code_d  = ST_BAD_MOD;
          state_d = FIN;
        end else if ((u_q == ZERO_W) || (u_q >= nm_q)) begin
          code_d  = ST_NOT_INV;
          state_d = FIN;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_inc_s;
        if ((u_q == ONE_W) || (v_q == ONE_W)) begin
          code_d  = ST_OK;
          state_d = FIN;
        end else if ((u_q == ZERO_W) || (v_q == ZERO_W)) begin
          code_d  = ST_NOT_INV;
          state_d = FIN;
        end else begin
          if (!u_q[0]) begin
            u_d  = u_q >> 1;
            x1_d = x1_half_s;
          end else if (!v_q[0]) begin
            v_d  = v_q >> 1;
            x2_d = x2_half_s;
          end else if (!u_sub_s[WIDTH]) begin
            u_d  = u_sub_s[WIDTH-1:0];
            x1_d = x1_diff_s;
          end else begin
            v_d  = v_sub_s;
            x2_d = x2_diff_s;
          end
          if (cnt_inc_s == CNT_MAX) begin
            code_d  = ST_TIMEOUT;
            state_d = FIN;
          end else begin
            state_d = RUN;
          end
        end
      end
      FIN: begin
        status_d = code_q;
        cycles_d = cnt_q;
        if (code_q != ST_OK) begin
          result_d = ZERO_W;
        end else if (neg_q) begin
          result_d = neg_inv_s;
        end else begin
          result_d = inv_s;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // in_ready rises one cycle after the result is taken, so it only ever shows in a settled IDLE.
    in_ready_d  = (state_q == IDLE) && (state_d == IDLE);
    out_valid_d = (state_d == HOLD);
  end

  // Control, datapath and output registers; reset discards any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      u_q         <= ZERO_W;
      v_q         <= ZERO_W;
      x1_q        <= ZERO_W;
      x2_q        <= ZERO_W;
      nm_q        <= ZERO_W;
      neg_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      code_q      <= ST_OK;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= ZERO_W;
      status_q    <= ST_OK;
      cycles_q    <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      u_q         <= u_d;
      v_q         <= v_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      nm_q        <= nm_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      status_q    <= status_d;
      cycles_q    <= cycles_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign status    = status_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_mmm_mod_inv_hs.sv
// tb_mmm_mod_inv_hs: self-checking bench for mmm_mod_inv_hs.
// A behavioural model predicts handshake timing and results every cycle;
// directed vectors pin literal expectations.
module tb_mmm_mod_inv_hs;

  localparam int W     = 260;
  localparam int MI    = 4 * W;
  localparam int CW    = $clog2(MI + 1);
  localparam int MI_TO = 4;
  localparam int CW_TO = $clog2(MI_TO + 1);
  localparam int NV    = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  n = '0;
  logic          neg = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic [1:0]    status;
  logic [CW-1:0] cycles;

  logic             t_in_valid = 1'b0;
  logic             t_in_ready;
  logic             t_out_valid;
  logic             t_out_ready = 1'b0;
  logic [W-1:0]     t_result;
  logic [1:0]       t_status;
  logic [CW_TO-1:0] t_cycles;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_cnt = 0;

  mmm_mod_inv_hs #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .n(n), .neg(neg), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .status(status), .cycles(cycles)
  );

  mmm_mod_inv_hs #(.WIDTH(W), .MAX_ITER(MI_TO)) dut_to (
    .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .a(a), .n(n), .neg(neg), .out_valid(t_out_valid), .out_ready(t_out_ready),
    .result(t_result), .status(t_status), .cycles(t_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the binary extended Euclid rules on plain integers.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mn, input logic mneg,
                                input int max_iter, output logic [W-1:0] res,
                                output logic [1:0] st, output int steps);
    logic [W:0] u, v, x1, x2, nn, inv;
    res = '0; st = 2'd0; steps = 0;
    nn = {1'b0, mn};
    u = {1'b0, ma}; v = nn; x1 = (W+1)'(1); x2 = '0;
    if (mn[0] == 1'b0 || mn < W'(3)) st = 2'd2;
    else if (ma == '0 || ma >= mn) st = 2'd1;
    else begin
      st = 2'd3;
      for (int k = 1; k <= max_iter; k++) begin
        steps = k;
        if (u == (W+1)'(1) || v == (W+1)'(1)) begin st = 2'd0; break; end
        else if (u == '0 || v == '0) begin st = 2'd1; break; end
        else if (!u[0]) begin u = u / 2; x1 = x1[0] ? (x1 + nn) / 2 : x1 / 2; end
        else if (!v[0]) begin v = v / 2; x2 = x2[0] ? (x2 + nn) / 2 : x2 / 2; end
        else if (u >= v) begin u = u - v; x1 = (x1 >= x2) ? x1 - x2 : x1 + nn - x2; end
        else begin v = v - u; x2 = (x2 >= x1) ? x2 - x1 : x2 + nn - x1; end
      end
      if (st == 2'd0) begin
        inv = (u == (W+1)'(1)) ? x1 : x2;
        if (mneg && inv != '0) inv = nn - inv;
        res = inv[W-1:0];
      end
    end
  endfunction

  // Independent check of an OK result: a * inverse == 1 mod n.
  function automatic logic inv_ok(input logic [W-1:0] ma, input logic [W-1:0] mn,
                                  input logic [W-1:0] r, input logic mneg);
    logic [2*W-1:0] prod;
    logic [W-1:0]   x;
    x = (mneg && r != '0) ? mn - r : r;
    prod = {{W{1'b0}}, ma} * {{W{1'b0}}, x};
    prod = prod % {{W{1'b0}}, mn};
    return prod == (2*W)'(1);
  endfunction

  // Per-cycle compare against the model; inputs are driven at posedge+1, sampled here.
  initial begin : model_proc
    logic         m_ready, m_valid, m_wait;
    int           m_cnt, e_cyc;
    logic [W-1:0] e_res;
    logic [1:0]   e_st;
    m_ready = 1'b1; m_valid = 1'b0; m_wait = 1'b0; m_cnt = 0;
    e_res = '0; e_st = 2'd0; e_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_result", result, W'(0));
        chk("rst_status", W'(status), W'(0));
        chk("rst_cycles", W'(cycles), W'(0));
        m_ready = 1'b1; m_valid = 1'b0; m_wait = 1'b0; m_cnt = 0;
      end else begin
        chk("cyc_in_ready", W'(in_ready), W'(m_ready));
        chk("cyc_out_valid", W'(out_valid), W'(m_valid));
        if (m_valid) begin
          chk("cyc_result", result, e_res);
          chk("cyc_status", W'(status), W'(e_st));
          chk("cyc_cycles", W'(cycles), W'(e_cyc));
        end
        if (m_ready && in_valid) begin
          model(a, n, neg, MI, e_res, e_st, e_cyc);
          if (e_st == 2'd0) chk("model_inverse", W'(inv_ok(a, n, e_res, neg)), W'(1));
          m_ready = 1'b0;
          m_cnt = 2 + e_cyc;
        end else if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
          m_wait = 1'b1;
        end else if (m_wait) begin
          m_wait = 1'b0;
          m_ready = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tn, input logic tneg,
                      output int unsigned t_acc);
    bit rdy = 1'b0;
    for (int k = 0; k < 100 && !rdy; k++) begin
      @(posedge clk); #1;
      if (in_ready) rdy = 1'b1;
    end
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL send_wait: in_ready got 0 expected 1");
    end
    a = ta; n = tn; neg = tneg; in_valid = 1'b1;
    @(posedge clk); #1;
    t_acc = cyc_cnt;
    in_valid = 1'b0;
  endtask

  task automatic get_result(input int hold, output logic [W-1:0] r, output logic [1:0] s,
                            output logic [CW-1:0] c, output int unsigned t_done);
    bit seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_out_valid: out_valid got 0 expected 1");
    end
    t_done = cyc_cnt; r = result; s = status; c = cycles;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [W-1:0] va [NV];
  logic [W-1:0] vn [NV];
  logic [W-1:0] vr [NV];
  logic         vneg [NV];
  logic [1:0]   vs [NV];

  task automatic setv(input int i, input logic [W-1:0] ta, input logic [W-1:0] tn, input logic tneg,
                      input logic [W-1:0] tr, input logic [1:0] ts);
    va[i] = ta; vn[i] = tn; vneg[i] = tneg; vr[i] = tr; vs[i] = ts;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [W-1:0]  p, r;
    logic [1:0]    s;
    logic [CW-1:0] c;
    int unsigned   t0, t1;
    int            msteps;
    bit            seen;

    p = (W'(1) << 255) - W'(19);

    // Pin the model with hand-computed cases.
    model(W'(3), W'(13), 1'b0, MI, r, s, msteps);
    chk("model_pin_3_13", r, W'(9));
    model(W'(6), W'(15), 1'b0, MI, r, s, msteps);
    chk("model_pin_6_15_status", W'(s), W'(1));
    model(W'(3), p, 1'b0, MI_TO, r, s, msteps);
    chk("model_pin_timeout_status", W'(s), W'(3));
    chk("model_pin_timeout_steps", W'(msteps), W'(4));

    setv(0,  W'(3),  W'(13),  1'b1, W'(4),   2'd0);
    setv(1,  W'(6),  W'(15),  1'b0, W'(0),   2'd1);
    setv(2,  W'(3),  W'(14),  1'b0, W'(0),   2'd2);
    setv(3,  W'(12), W'(13),  1'b0, W'(12),  2'd0);
    setv(4,  W'(7),  W'(255), 1'b0, W'(73),  2'd0);
    setv(5,  W'(7),  W'(255), 1'b1, W'(182), 2'd0);
    setv(6,  W'(13), W'(13),  1'b0, W'(0),   2'd1);
    setv(7,  W'(0),  W'(13),  1'b0, W'(0),   2'd1);
    setv(8,  W'(5),  W'(1),   1'b0, W'(0),   2'd2);
    setv(9,  W'(0),  W'(14),  1'b0, W'(0),   2'd2);
    setv(10, W'(2),  p,       1'b0, (p + W'(1)) >> 1, 2'd0);
    setv(11, W'(2),  p,       1'b1, (p - W'(1)) >> 1, 2'd0);
    setv(12, W'(14), W'(13),  1'b0, W'(0),   2'd1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic inverse with backpressure and a request offered during HOLD.
    send(W'(3), W'(13), 1'b0, t0);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("bp_seen_out_valid", W'(seen), W'(1));
    chk("bp_result", result, W'(9));
    chk("bp_status", W'(status), W'(0));
    in_valid = 1'b1; a = W'(5); n = W'(13); neg = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_out_valid", W'(out_valid), W'(1));
      chk("bp_hold_in_ready", W'(in_ready), W'(0));
      chk("bp_hold_result", result, W'(9));
      chk("bp_hold_status", W'(status), W'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_out_valid", W'(out_valid), W'(0));
    chk("bp_release_in_ready", W'(in_ready), W'(0));
    @(posedge clk); #1;
    chk("bp_after_in_ready", W'(in_ready), W'(1));

    // a=1: one RUN step, result three cycles after accept.
    send(W'(1), W'(13), 1'b0, t0);
    get_result(0, r, s, c, t1);
    chk("a1_result", r, W'(1));
    chk("a1_status", W'(s), W'(0));
    chk("a1_cycles", W'(c), W'(1));
    chk("a1_latency", W'(t1 - t0), W'(3));

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      send(va[i], vn[i], vneg[i], t0);
      get_result(i % 3, r, s, c, t1);
      chk($sformatf("vec%0d_result", i), r, vr[i]);
      chk($sformatf("vec%0d_status", i), W'(s), W'(vs[i]));
    end

    // Step budget exhausted on the MAX_ITER=4 instance.
    @(posedge clk); #1;
    chk("to_in_ready", W'(t_in_ready), W'(1));
    a = W'(3); n = p; neg = 1'b0; t_in_valid = 1'b1;
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk); #1;
      if (t_out_valid) seen = 1'b1;
    end
    chk("to_seen_out_valid", W'(seen), W'(1));
    chk("to_status", W'(t_status), W'(3));
    chk("to_cycles", W'(t_cycles), W'(4));
    chk("to_result", t_result, W'(0));
    t_out_ready = 1'b1;
    @(posedge clk); #1;
    t_out_ready = 1'b0;

    // Reset in the middle of a long RUN discards the job.
    send(W'(3), p, 1'b0, t0);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", W'(in_ready), W'(1));
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_result", result, W'(0));
    chk("midrst_status", W'(status), W'(0));
    chk("midrst_cycles", W'(cycles), W'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(W'(5), W'(13), 1'b0, t0);
    get_result(1, r, s, c, t1);
    chk("post_rst_result", r, W'(8));
    chk("post_rst_status", W'(s), W'(0));

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
